lobster_fetch_unit: RTL and testbench

Instruction fetch front end that feeds the execution manager. It tracks a fetch pointer and issues 64-bit bundle read requests to the memory/I-side bus. Returned bundles, each tagged with its address, are buffered in a small FIFO and presented to the execution manager over a valid/ready interface. Control-flow changes reported by the execution manager redirect the fetch stream and flush stale work.

---
 rtl/lobster_fetch_unit_if.sv | 25 ++
 rtl/lobster_fetch_unit.sv | 133 +++++++++++++
 tb/tb_lobster_fetch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lobster_fetch_unit_if.sv
// rtl/lobster_fetch_unit_if.sv - memory request bus and bundle stream of the fetch unit
interface lobster_fetch_unit_if #(
  parameter int ADDR_WIDTH = 36
) ();
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [63:0]           mem_data;
  logic                  mem_err;
  logic                  bundle_valid;
  logic                  bundle_ready;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [63:0]           data_out;
  logic                  fault;

  modport master (
    output mem_req, mem_addr, bundle_valid, addr_out, data_out, fault,
    input  mem_ack, mem_data, mem_err, bundle_ready
  );

  modport slave (
    input  mem_req, mem_addr, bundle_valid, addr_out, data_out, fault,
    output mem_ack, mem_data, mem_err, bundle_ready
  );
endinterface

// File: rtl/lobster_fetch_unit.sv
// rtl/lobster_fetch_unit.sv - fetch pointer, single-outstanding bundle reads, bundle FIFO
module lobster_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 36,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 36'hF800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ip_in,
  input  logic                  redirect,
  lobster_fetch_unit_if.master  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] fp, fp_n, req_addr, req_addr_n, redir_fp;
  logic                  drop, drop_n;
  logic                  push, push_fault, pop, flush;
  logic [CNT_W-1:0]      count, cnt_after;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [63:0]           fifo_data  [FIFO_DEPTH];
  logic                  fifo_fault [FIFO_DEPTH];

  assign redir_fp         = ip_in & ~ADDR_WIDTH'(7);
  assign bus.mem_req      = (state == S_WAIT);
  assign bus.mem_addr     = req_addr;
  assign bus.bundle_valid = (count != '0);
  assign bus.addr_out     = bus.bundle_valid ? fifo_addr[rd_ptr] : '0;
  assign bus.data_out     = bus.bundle_valid ? fifo_data[rd_ptr] : '0;
  assign bus.fault        = bus.bundle_valid & fifo_fault[rd_ptr];
  assign pop              = bus.bundle_valid & bus.bundle_ready;
  assign cnt_after        = count + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_n    = state;
    fp_n       = fp;
    req_addr_n = req_addr;
    drop_n     = drop;
    push       = 1'b0;
    push_fault = 1'b0;
    flush      = 1'b0;
    case (state)
      S_FETCH: begin
        if (redirect) begin
          flush      = 1'b1;
          fp_n       = redir_fp;
          req_addr_n = redir_fp;
          state_n    = S_WAIT;
        end else if (count < DEPTH_C) begin
          req_addr_n = fp;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          if (redirect) begin
            // response discarded; the flushed FIFO always has room for the new request
            flush      = 1'b1;
            drop_n     = 1'b0;
            fp_n       = redir_fp;
            req_addr_n = redir_fp;
          end else if (drop) begin
            drop_n     = 1'b0;
            req_addr_n = fp;
            if (count >= DEPTH_C) state_n = S_FETCH;
          end else if (bus.mem_err) begin
            push       = 1'b1;
            push_fault = 1'b1;
            state_n    = S_HALT;
          end else begin
            push       = 1'b1;
            fp_n       = fp + ADDR_WIDTH'(8);
            req_addr_n = fp + ADDR_WIDTH'(8);
            if (cnt_after >= DEPTH_C) state_n = S_FETCH;
          end
        end else if (redirect) begin
          // the pending request cannot be withdrawn; mark its response stale
          flush  = 1'b1;
          drop_n = 1'b1;
          fp_n   = redir_fp;
        end
      end
      S_HALT: begin
        if (redirect) begin
          flush   = 1'b1;
          fp_n    = redir_fp;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      fp       <= RESET_VECTOR;
      req_addr <= '0;
      drop     <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_n;
      fp       <= fp_n;
      req_addr <= req_addr_n;
      drop     <= drop_n;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_data[wr_ptr]  <= push_fault ? 64'd0 : bus.mem_data;
      fifo_fault[wr_ptr] <= push_fault;
    end
  end
endmodule

// File: tb/tb_lobster_fetch_unit.sv
// tb/tb_lobster_fetch_unit.sv - directed self-checking bench for lobster_fetch_unit
module tb_lobster_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] ip_in;
  logic        redirect;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] a;

  lobster_fetch_unit_if #(.ADDR_WIDTH(36)) bus ();

  lobster_fetch_unit #(
    .ADDR_WIDTH(36), .FIFO_DEPTH(4), .RESET_VECTOR(36'hF800)
  ) dut (
    .clk(clk), .rst(rst), .ip_in(ip_in), .redirect(redirect), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; ip_in = '0;
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_data = '0; bus.bundle_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset state and first request
    rst = 1'b1; redirect = 1'b0; ip_in = '0;
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_data = '0; bus.bundle_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_valid", bus.bundle_valid, 0);
    chk("rst_addr_out", bus.addr_out, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_fault", bus.fault, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_mem_req", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 36'hF800);
    chk("t1_valid", bus.bundle_valid, 0);
    chk("t1_fault", bus.fault, 0);

    // 2: streaming with consumer always ready
    bus.bundle_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 36'hF800 + 36'(8 * i);
      chk("t2_mem_addr", bus.mem_addr, a);
      bus.mem_ack = 1'b1; bus.mem_data = {28'd0, a} ^ 64'hA5;
      @(negedge clk);
      chk("t2_valid", bus.bundle_valid, 1);
      chk("t2_addr_out", bus.addr_out, a);
      chk("t2_data_out", bus.data_out, {28'd0, a} ^ 64'hA5);
    end
    bus.mem_ack = 1'b0;

    // 3: FIFO fills, request stops, one pop restarts fetch
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 36'hF800 + 36'(8 * i);
      chk("t3_mem_req", bus.mem_req, 1);
      chk("t3_mem_addr", bus.mem_addr, a);
      bus.mem_ack = 1'b1; bus.mem_data = {28'd0, a} ^ 64'hA5;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    chk("t3_req_drop", bus.mem_req, 0);
    chk("t3_head", bus.addr_out, 36'hF800);
    @(negedge clk);
    chk("t3_req_still0", bus.mem_req, 0);
    chk("t3_head_stable", bus.addr_out, 36'hF800);
    chk("t3_data_stable", bus.data_out, 64'hF800 ^ 64'hA5);
    bus.bundle_ready = 1'b1;
    @(negedge clk);
    bus.bundle_ready = 1'b0;
    chk("t3_head_after_pop", bus.addr_out, 36'hF808);
    chk("t3_data_after_pop", bus.data_out, 64'hF808 ^ 64'hA5);
    @(negedge clk);
    chk("t3_req_again", bus.mem_req, 1);
    chk("t3_addr_again", bus.mem_addr, 36'hF820);

    // 4: redirect while a request is pending
    do_reset();
    bus.mem_ack = 1'b1; bus.mem_data = 64'hF800 ^ 64'hA5;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("t4_pending_addr", bus.mem_addr, 36'hF808);
    redirect = 1'b1; ip_in = 36'h1234F;
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_held_req", bus.mem_req, 1);
    chk("t4_held_addr", bus.mem_addr, 36'hF808);
    chk("t4_flushed", bus.bundle_valid, 0);
    @(negedge clk);
    chk("t4_held_addr2", bus.mem_addr, 36'hF808);
    bus.mem_ack = 1'b1; bus.mem_data = 64'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("t4_dropped", bus.bundle_valid, 0);
    chk("t4_new_req", bus.mem_req, 1);
    chk("t4_new_addr", bus.mem_addr, 36'h12348);
    @(negedge clk);
    chk("t4_still_empty", bus.bundle_valid, 0);

    // 5: bus error parks the unit until a redirect
    do_reset();
    bus.bundle_ready = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_data = 64'hF800 ^ 64'hA5;
    @(negedge clk);
    bus.mem_err = 1'b1; bus.mem_data = 64'h1111_2222;
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.bundle_ready = 1'b0;
    chk("t5_valid", bus.bundle_valid, 1);
    chk("t5_fault", bus.fault, 1);
    chk("t5_addr_out", bus.addr_out, 36'hF808);
    chk("t5_data_out", bus.data_out, 0);
    for (int i = 0; i < 20; i++) begin
      chk("t5_halt_no_req", bus.mem_req, 0);
      @(negedge clk);
    end
    chk("t5_fault_kept", bus.fault, 1);
    redirect = 1'b1; ip_in = 36'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("t5_flushed", bus.bundle_valid, 0);
    @(negedge clk);
    chk("t5_resume_req", bus.mem_req, 1);
    chk("t5_resume_addr", bus.mem_addr, 36'h100);

    // 6: fetch pointer wraps at the top of the address space
    do_reset();
    redirect = 1'b1; ip_in = 36'hFFFFFFFF8;
    @(negedge clk);
    redirect = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_data = 64'h5;
    @(negedge clk);
    chk("t6_top_addr", bus.mem_addr, 36'hFFFFFFFF8);
    bus.mem_ack = 1'b1; bus.mem_data = 64'h77;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("t6_wrap_addr", bus.mem_addr, 36'h0);
    chk("t6_head_addr", bus.addr_out, 36'hFFFFFFFF8);
    chk("t6_head_data", bus.data_out, 64'h77);

    // 7: redirect coinciding with an ack
    do_reset();
    redirect = 1'b1; ip_in = 36'h2004;
    bus.mem_ack = 1'b1; bus.mem_data = 64'h99;
    @(negedge clk);
    redirect = 1'b0; bus.mem_ack = 1'b0;
    chk("t7_req", bus.mem_req, 1);
    chk("t7_addr", bus.mem_addr, 36'h2000);
    chk("t7_discarded", bus.bundle_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
